// File: rtl/axis_fifo_half.sv
//==============================================================================
// Module   : axis_fifo_half
// Purpose  : Width-halving AXI Stream FIFO. Double-width words (two narrow
//            beats, earlier beat in the lower half) are buffered in an
//            inferred dual-port RAM. They are emitted as narrow beats, lower
//            half first. The upper half of a tlast word whose upper tkeep is
//            all zero is dropped.
// Ports    : aclk, resetn (sync, active-low)
//            write_*  : double-width AXIS slave (tdata/tkeep/tuser/tlast,
//                       tvalid/tready)
//            read_*   : narrow AXIS master (tdata/tkeep/tuser/tlast,
//                       tvalid/tready)
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module axis_fifo_half #(
   parameter int AXIS_DATA_WIDTH  = 512,
   parameter int AXIS_TUSER_WIDTH = 256,
   parameter int ADDR_WIDTH       = 12
) (
   input  logic                            aclk,
   input  logic                            resetn,
   input  logic [AXIS_DATA_WIDTH*2-1:0]    write_tdata,
   input  logic [AXIS_DATA_WIDTH/8*2-1:0]  write_tkeep,
   input  logic [AXIS_TUSER_WIDTH*2-1:0]   write_tuser,
   input  logic                            write_tvalid,
   input  logic                            write_tlast,
   output logic                            write_tready,
   output logic [AXIS_DATA_WIDTH-1:0]      read_tdata,
   output logic [AXIS_DATA_WIDTH/8-1:0]    read_tkeep,
   output logic [AXIS_TUSER_WIDTH-1:0]     read_tuser,
   output logic                            read_tvalid,
   output logic                            read_tlast,
   input  logic                            read_tready
);

   localparam int DW     = AXIS_DATA_WIDTH;
   localparam int KW     = AXIS_DATA_WIDTH / 8;
   localparam int UW     = AXIS_TUSER_WIDTH;
   localparam int WORD_W = 2*DW + 2*KW + 2*UW + 1;
   localparam int DEPTH  = 1 << ADDR_WIDTH;
   localparam logic [ADDR_WIDTH:0] PTR_ONE = 1;

   logic [WORD_W-1:0]   mem [DEPTH];

   logic [ADDR_WIDTH:0] wr_ptr;
   logic [ADDR_WIDTH:0] wr_ptr_seen;   // wr_ptr delayed one cycle
   logic [ADDR_WIDTH:0] rd_ptr;

   // Output stage: the RAM's registered read port doubles as the word holder.
   logic [WORD_W-1:0]   stage_word;
   logic                stage_valid;
   logic                stage_half;

   logic [2*DW-1:0]     word_data;
   logic [2*KW-1:0]     word_keep;
   logic [2*UW-1:0]     word_user;
   logic                word_last;

   logic full;
   logic write_fire;
   logic ram_avail;
   logic skip_upper;
   logic read_fire;
   logic word_done;
   logic load;

   assign full = (wr_ptr[ADDR_WIDTH] != rd_ptr[ADDR_WIDTH]) &&
                 (wr_ptr[ADDR_WIDTH-1:0] == rd_ptr[ADDR_WIDTH-1:0]);
   assign write_tready = ~full;
   assign write_fire   = write_tvalid & ~full;

   // Emptiness is judged against the delayed write pointer. This gives the
   // fixed two-cycle write-to-valid latency and guarantees a RAM location is
   // never read on the same edge it is written.
   assign ram_avail = (wr_ptr_seen != rd_ptr);

   assign {word_data, word_keep, word_user, word_last} = stage_word;

   // Only a packet-final word with an empty upper half collapses to one beat.
   assign skip_upper = word_last & (word_keep[2*KW-1:KW] == '0);
   assign read_fire  = stage_valid & read_tready;
   assign word_done  = read_fire & (stage_half | skip_upper);
   assign load       = (~stage_valid | word_done) & ram_avail;

   // RAM write port (no reset: contents are qualified by the pointers).
   always_ff @(posedge aclk) begin
      if (write_fire) begin
         mem[wr_ptr[ADDR_WIDTH-1:0]] <= {write_tdata, write_tkeep, write_tuser, write_tlast};
      end
   end

   // RAM registered read port / output word.
   always_ff @(posedge aclk) begin
      if (!resetn) begin
         stage_word <= '0;
      end else if (load) begin
         stage_word <= mem[rd_ptr[ADDR_WIDTH-1:0]];
      end
   end

   always_ff @(posedge aclk) begin
      if (!resetn) begin
         wr_ptr      <= '0;
         wr_ptr_seen <= '0;
         rd_ptr      <= '0;
         stage_valid <= 1'b0;
         stage_half  <= 1'b0;
      end else begin
         wr_ptr_seen <= wr_ptr;
         if (write_fire) begin
            wr_ptr <= wr_ptr + PTR_ONE;
         end
         if (load) begin
            rd_ptr <= rd_ptr + PTR_ONE;
         end

         if (load) begin
            stage_valid <= 1'b1;
         end else if (word_done) begin
            stage_valid <= 1'b0;
         end

         // A finished word always returns to the lower half, so a freshly
         // loaded word starts there too.
         if (word_done) begin
            stage_half <= 1'b0;
         end else if (read_fire) begin
            stage_half <= 1'b1;
         end
      end
   end

   assign read_tvalid = stage_valid;
   assign read_tdata  = stage_half ? word_data[2*DW-1:DW] : word_data[DW-1:0];
   assign read_tkeep  = stage_half ? word_keep[2*KW-1:KW] : word_keep[KW-1:0];
   assign read_tuser  = stage_half ? word_user[2*UW-1:UW] : word_user[UW-1:0];
   assign read_tlast  = stage_half ? word_last : skip_upper;

endmodule

`default_nettype wire

// File: tb/tb_axis_fifo_half.sv
//==============================================================================
// Module   : tb_axis_fifo_half
// Purpose  : Self-checking bench for axis_fifo_half. A queue of expected
//            narrow beats is built from each accepted double-width word and
//            every presented output beat is compared against its head.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_axis_fifo_half;

   localparam int W     = 16;
   localparam int U     = 4;
   localparam int K     = W / 8;
   localparam int AW    = 3;
   localparam int DEPTH = 1 << AW;

   logic              aclk = 1'b0;
   logic              resetn = 1'b0;
   logic [2*W-1:0]    write_tdata = '0;
   logic [2*K-1:0]    write_tkeep = '0;
   logic [2*U-1:0]    write_tuser = '0;
   logic              write_tvalid = 1'b0;
   logic              write_tlast = 1'b0;
   logic              write_tready;
   logic [W-1:0]      read_tdata;
   logic [K-1:0]      read_tkeep;
   logic [U-1:0]      read_tuser;
   logic              read_tvalid;
   logic              read_tlast;
   logic              read_tready = 1'b0;

   axis_fifo_half #(
      .AXIS_DATA_WIDTH  (W),
      .AXIS_TUSER_WIDTH (U),
      .ADDR_WIDTH       (AW)
   ) dut (
      .aclk         (aclk),
      .resetn       (resetn),
      .write_tdata  (write_tdata),
      .write_tkeep  (write_tkeep),
      .write_tuser  (write_tuser),
      .write_tvalid (write_tvalid),
      .write_tlast  (write_tlast),
      .write_tready (write_tready),
      .read_tdata   (read_tdata),
      .read_tkeep   (read_tkeep),
      .read_tuser   (read_tuser),
      .read_tvalid  (read_tvalid),
      .read_tlast   (read_tlast),
      .read_tready  (read_tready)
   );

   always #5 aclk = ~aclk;

   int          total = 0;
   int          bad = 0;
   int          cyc = 0;
   int          first_rd = -1;
   int          last_rd = -1;
   int          nrd = 0;
   logic        w_hs = 1'b0;
   logic        rand_ready = 1'b0;
   logic [63:0] q[$];

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One clock: evaluate handshakes mid-cycle, update the model, advance.
   task automatic tick();
      logic        r_hs;
      logic [63:0] beat;
      logic [63:0] lo;
      logic [63:0] hi;
      logic        skip;
      @(negedge aclk);
      w_hs = resetn & write_tvalid & write_tready;
      r_hs = resetn & read_tvalid & read_tready;
      if (!resetn) begin
         q.delete();
      end else begin
         if (read_tvalid) begin
            beat = 64'({read_tdata, read_tkeep, read_tuser, read_tlast});
            if (q.size() == 0) begin
               check("spurious_beat", 64'(read_tvalid), 64'd0);
            end else begin
               check("beat", beat, q[0]);
            end
         end
         if (r_hs) begin
            if (q.size() != 0) void'(q.pop_front());
            if (first_rd < 0) first_rd = cyc;
            last_rd = cyc;
            nrd++;
         end
         if (w_hs) begin
            skip = write_tlast && (write_tkeep[2*K-1:K] == '0);
            lo = 64'({write_tdata[W-1:0], write_tkeep[K-1:0], write_tuser[U-1:0], skip});
            hi = 64'({write_tdata[2*W-1:W], write_tkeep[2*K-1:K], write_tuser[2*U-1:U], write_tlast});
            q.push_back(lo);
            if (!skip) q.push_back(hi);
         end
      end
      @(posedge aclk);
      #1;
      cyc++;
      if (rand_ready) read_tready = 1'($urandom_range(0, 1));
   endtask

   task automatic push_word(input logic [2*W-1:0] d, input logic [2*K-1:0] k,
                            input logic [2*U-1:0] u, input logic l);
      int n;
      n = 0;
      write_tdata  = d;
      write_tkeep  = k;
      write_tuser  = u;
      write_tlast  = l;
      write_tvalid = 1'b1;
      do begin
         tick();
         n++;
      end while (!w_hs && n < 200);
      if (!w_hs) check("write_accept_timeout", 64'(w_hs), 64'd1);
   endtask

   task automatic idle_write();
      write_tvalid = 1'b0;
   endtask

   task automatic drain(input int budget);
      int n;
      n = 0;
      while (q.size() != 0 && n < budget) begin
         tick();
         n++;
      end
      check("drain_left", 64'(q.size()), 64'd0);
      repeat (4) tick();
   endtask

   task automatic do_reset();
      resetn = 1'b0;
      repeat (2) tick();
      resetn = 1'b1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic        acc;
      int          n;
      logic [2*W-1:0] d;
      logic [2*K-1:0] k;

      // Reset state
      #1;
      do_reset();
      check("reset_tvalid", 64'(read_tvalid), 64'd0);
      check("reset_tlast",  64'(read_tlast),  64'd0);
      check("reset_tdata",  64'(read_tdata),  64'd0);
      check("reset_tkeep",  64'(read_tkeep),  64'd0);
      check("reset_tuser",  64'(read_tuser),  64'd0);
      check("reset_tready", 64'(write_tready), 64'd1);

      // Single full word {B,A}, tlast: two beats, two-cycle latency
      push_word({16'hBBBB, 16'hAAAA}, 4'hF, 8'h5A, 1'b1);
      idle_write();
      check("lat_edgeN",   64'(read_tvalid), 64'd0);
      tick();
      check("lat_edgeN1",  64'(read_tvalid), 64'd0);
      tick();
      check("lat_edgeN2",  64'(read_tvalid), 64'd1);
      read_tready = 1'b1;
      drain(50);

      // tlast word with empty upper half: single beat
      push_word({16'h1234, 16'h5678}, 4'b0011, 8'hC3, 1'b1);
      idle_write();
      nrd = 0;
      drain(50);
      check("skip_beat_count", 64'(nrd), 64'd1);

      // 3-word packet, ready held high: 6 gap-free beats
      first_rd = -1; last_rd = -1; nrd = 0;
      push_word({16'h0102, 16'h0304}, 4'hF, 8'h11, 1'b0);
      push_word({16'h0506, 16'h0708}, 4'hF, 8'h22, 1'b0);
      push_word({16'h090A, 16'h0B0C}, 4'hF, 8'h33, 1'b1);
      idle_write();
      drain(50);
      check("burst_beats", 64'(nrd), 64'd6);
      check("burst_span",  64'(last_rd - first_rd), 64'd5);

      // Fill to capacity with output stalled, then drain with pointer wrap
      read_tready = 1'b0;
      for (int i = 0; i < DEPTH + 1; i++) begin
         push_word(32'(32'hA000_0000 + i * 32'h0001_0003), 4'hF, 8'(i), (i == DEPTH));
      end
      check("full_tready", 64'(write_tready), 64'd0);
      write_tdata = 32'hDEAD_BEEF;
      write_tkeep = 4'hF;
      write_tuser = 8'hEE;
      write_tlast = 1'b1;
      acc = 1'b0;
      repeat (3) begin
         tick();
         acc = acc | w_hs;
      end
      check("full_stall", 64'(acc), 64'd0);
      check("full_qsize", 64'(q.size()), 64'(2 * (DEPTH + 1)));
      read_tready = 1'b1;
      n = 0;
      do begin
         tick();
         n++;
      end while (!w_hs && n < 50);
      check("stalled_write_taken", 64'(w_hs), 64'd1);
      idle_write();
      drain(100);

      // Random backpressure over a 10-word packet
      rand_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         d = $urandom();
         k = 4'($urandom());
         push_word(d, k, 8'($urandom()), (i == 9));
      end
      idle_write();
      drain(400);
      rand_ready = 1'b0;

      // Reset after the lower half of a word has been consumed
      read_tready = 1'b0;
      push_word({16'hCAFE, 16'hF00D}, 4'hF, 8'h77, 1'b0);
      idle_write();
      n = 0;
      while (!read_tvalid && n < 10) begin
         tick();
         n++;
      end
      check("pre_reset_valid", 64'(read_tvalid), 64'd1);
      read_tready = 1'b1;
      tick();
      read_tready = 1'b0;
      resetn = 1'b0;
      tick();
      check("midreset_tvalid", 64'(read_tvalid), 64'd0);
      check("midreset_tdata",  64'(read_tdata),  64'd0);
      resetn = 1'b1;
      read_tready = 1'b1;
      nrd = 0;
      push_word({16'h2B2B, 16'h1A1A}, 4'hF, 8'h99, 1'b1);
      idle_write();
      drain(50);
      check("post_reset_beats", 64'(nrd), 64'd2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/axis_fifo_half.md
Name: axis_fifo_half

Overview:
- Width-halving AXI Stream FIFO; the unpacking counterpart of the double-width packing FIFO.
- Accepts double-width beats (two narrow beats per word, earlier beat in the lower half).
- Buffers them in an inferred dual-port RAM.
- Emits narrow beats, lower half first, then upper half.
- Sits on the restore path of the migrator, feeding single-width AXIS consumers from double-width storage/transport.

Parameters:
- AXIS_DATA_WIDTH, 512, narrow tdata width; write side is twice this.
- AXIS_TUSER_WIDTH, 256, narrow tuser width; write side is twice this.
- ADDR_WIDTH, 12, RAM depth is 2^ADDR_WIDTH double-width words.

Ports:
- aclk  in  1  clock; all logic on rising edge.
- resetn  in  1  synchronous, active-low reset.
- write_tdata  in  AXIS_DATA_WIDTH*2  [W-1:0] = first narrow beat, [2W-1:W] = second.
- write_tkeep  in  AXIS_DATA_WIDTH/8*2  byte enables, same half split as tdata.
- write_tuser  in  AXIS_TUSER_WIDTH*2  sideband, same half split.
- write_tvalid  in  1  slave valid.
- write_tlast  in  1  word holds the final narrow beat(s) of a packet.
- write_tready  out  1  high when RAM not full.
- read_tdata  out  AXIS_DATA_WIDTH  narrow beat data.
- read_tkeep  out  AXIS_DATA_WIDTH/8  narrow beat byte enables.
- read_tuser  out  AXIS_TUSER_WIDTH  narrow beat sideband.
- read_tvalid  out  1  master valid.
- read_tlast  out  1  packet end.
- read_tready  in  1  master ready.

Behaviour:
- Reset (resetn low at a rising edge):
  - write_ptr, read_ptr (ADDR_WIDTH+1 bits) cleared to 0.
  - Output stage emptied; half select cleared to 0 (lower).
  - read_tvalid, read_tlast, read_tkeep, read_tdata, read_tuser all 0.
  - write_tready is 1 on the cycle after reset.
  - Reset mid-packet discards all stored and in-flight data; no partial beat is emitted afterwards.
- RAM word: {tdata, tkeep, tuser, tlast}, 1 write port, 1 registered read port.
- Write side:
  - full = MSBs of the pointers differ and lower bits are equal; write_tready = ~full.
  - A handshake (tvalid & tready) writes at write_ptr[ADDR_WIDTH-1:0]; write_ptr then increments and wraps modulo 2^(ADDR_WIDTH+1).
- Output stage:
  - Holds one word plus a half flag.
  - When the stage is empty, or its last half is being consumed this cycle, and the RAM is non-empty, the next word is read and read_ptr increments.
  - Capacity is 2^ADDR_WIDTH + 1 words.
- Latency: a write handshake at edge N into an empty block gives read_tvalid high after edge N+2. Sustained throughput is 1 narrow beat per cycle, with no bubble between words.
- Half emission:
  - half=0 presents the lower slices. read_tlast = word_tlast & (upper tkeep == 0); otherwise 0.
  - On a read handshake at half=0:
    - If word_tlast is set and upper tkeep == 0, the word is done: load the next word or go empty, and half stays 0.
    - Otherwise half becomes 1.
  - half=1 presents the upper slices with read_tlast = word_tlast. A handshake completes the word and half returns to 0.
- The upper half is skipped only on a tlast word with all-zero upper tkeep. Mid-packet words always emit both halves, tkeep passed through unchanged.
- Output signals stay stable while read_tvalid & ~read_tready (AXIS hold rule).
- Simultaneous write into empty RAM while the stage drains its final half: the word does not bypass the RAM; it follows the normal 2-cycle latency.
- Simultaneous write and read when full: the read frees a slot, but write_tready stays 0 that cycle (registered full).

Test Plan:
- Reset, then one word with tdata={B,A}, tkeep all ones, tlast=1 -> beats A (last=0) then B (last=1); read_tvalid rises 2 cycles after the write.
- tlast word with upper tkeep=0 and lower tkeep=0x0F…F -> a single beat, lower data, read_tlast=1, no second beat.
- 3-word packet, read_tready held high -> 6 consecutive beats with no gaps; tlast only on the 6th.
- read_tready held low: write 2^ADDR_WIDTH+1 words -> write_tready drops; a further write stalls; releasing read_tready drains all words in order with pointer wrap.
- Random read_tready toggling on a 10-word packet -> data, tkeep, tuser and tlast match the golden unpacked stream, stable while stalled.
- resetn asserted after the lower half of a word is consumed -> read_tvalid 0 next cycle; a new packet after reset emits only its own beats.
